// File: rtl/dm_port_sched.sv
// dm_port_sched: data-memory port scheduler.
// Shares one single-port synchronous data RAM between the MEM-stage load/store
// port and a secondary word-wide port (debug/DMA). It also drives the
// load-extension unit with the registered byte offset and load op.
// Optional feature macro: ALIGN_CHECK_EN (misaligned half/word accesses raise
// p_err and are dropped instead of being issued to the RAM).
module dm_port_sched #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [2:0]        p_op,
  input  logic [31:0]       p_addr,
  input  logic [31:0]       p_wdata,
  output logic              p_stall,
  output logic              p_rvalid,
  output logic [31:0]       p_rdata,
  output logic              p_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_be,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [1:0]        ext_A,
  output logic [2:0]        ext_Op,
  output logic [31:0]       ext_Din,
  input  logic [31:0]       ext_Dout
);

  localparam int unsigned CNT_W   = 8;
  localparam logic [2:0]  OP_BYTE = 3'b010;
  localparam logic [2:0]  OP_HALF = 3'b100;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    P_RD = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;

  logic misalign;
  logic d_win;
  logic p_win;
  logic p_go;
  logic p_load;

  // Address bits that the word-addressed RAM never sees.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{p_addr[31:ADDR_W+2], d_addr[31:ADDR_W+2], d_addr[1:0]};

  // Misalignment detection (only active with the alignment check built in).
`ifdef ALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    if (p_op == OP_HALF)
      misalign = p_addr[0];
    else if (p_op != OP_BYTE)
      misalign = (p_addr[1:0] != 2'b00);
  end
`else
  assign misalign = 1'b0;
`endif

  // Arbitration: secondary wins in P_RD, when starved, or when the pipeline is quiet.
  always_comb begin
    d_win  = d_req && ((state == P_RD) || !p_req ||
                       (starve_cnt == CNT_W'(STARVE_MAX)));
    p_win  = p_req && (state == IDLE) && !d_win;
    p_go   = p_win && !misalign;
    p_load = p_go && !p_we;
  end

  // RAM request, byte enables and lane-replicated write data.
  always_comb begin
    ram_en    = 1'b0;
    ram_be    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = 32'h0;
    d_gnt     = d_win;
    p_err     = p_win && misalign;
    p_stall   = (p_req && (state == IDLE) && !p_win) || p_load;
    if (d_win) begin
      ram_en    = 1'b1;
      ram_addr  = d_addr[ADDR_W+1:2];
      ram_be    = d_we ? 4'b1111 : 4'b0000;
      ram_wdata = d_wdata;
    end else if (p_go) begin
      ram_en   = 1'b1;
      ram_addr = p_addr[ADDR_W+1:2];
      if (p_op == OP_BYTE) begin
        ram_wdata = {4{p_wdata[7:0]}};
        if (p_we) ram_be = 4'b0001 << p_addr[1:0];
      end else if (p_op == OP_HALF) begin
        ram_wdata = {2{p_wdata[15:0]}};
        if (p_we) ram_be = p_addr[1] ? 4'b1100 : 4'b0011;
      end else begin
        ram_wdata = p_wdata;
        if (p_we) ram_be = 4'b1111;
      end
    end
  end

  // Read-return data paths are straight pass-throughs of the RAM/extender.
  assign ext_Din = ram_rdata;
  assign p_rdata = ext_Dout;
  assign d_rdata = ram_rdata;

  // State, starvation counter and registered return/extension controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      ext_A      <= 2'b00;
      ext_Op     <= 3'b000;
      p_rvalid   <= 1'b0;
      d_rvalid   <= 1'b0;
    end else begin
      state    <= p_load ? P_RD : IDLE;
      p_rvalid <= p_load;
      d_rvalid <= d_win && !d_we;
      if (p_load) begin
        ext_A  <= p_addr[1:0];
        ext_Op <= p_op;
      end
      if (d_req && !d_win) begin
        if (starve_cnt != CNT_W'(STARVE_MAX))
          starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule
